// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low-speed/full-speed transmit serializer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    // Bit i is the i-th SYNC bit in time order.
    localparam logic [7:0] SYNC_PATTERN = 8'b10000000;
    localparam int         STUFF_LIMIT  = 6;
    localparam int         EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_serializer_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and strobes bit_end on the last clock of each period.
module tx_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic clear,
    output logic bit_end
);

    logic [7:0] cnt;

    assign bit_end = (cnt == 8'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: SYNC, NRZI payload (LSB first), EOP.
// Build option: define USB_TX_STUFF_EN to insert a 0 after every six consecutive 1 bits.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_error
);

    // Handshake: the first byte of a packet is taken when tx_valid is seen in IDLE;
    // every later byte transfers on a cycle with tx_valid && tx_ready. tx_ready asks for
    // the byte after the one about to be shifted, so a non-last byte always has its
    // successor in hand; a refused request (underrun) ends the packet with EOP.

    tx_state_t  state, state_n;
    logic [7:0] sr, sr_n;
    logic [7:0] nxt, nxt_n;
    logic       cur_last, cur_last_n;
    logic       nxt_last, nxt_last_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       dp_n, dm_n;
    logic       bit_end;
    logic       emit, emit_bit, load_next, ready_slot;
    logic       stuff_due;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .clear  (rst || (state == ST_IDLE)),
        .bit_end(bit_end)
    );

`ifdef USB_TX_STUFF_EN
    logic [2:0] ones;
    logic       in_stuff;
    logic       do_stuff;

    assign stuff_due = !in_stuff && (ones == 3'(STUFF_LIMIT));
    assign do_stuff  = (state == ST_DATA) && bit_end && stuff_due;

    always_ff @(posedge clk) begin
        if (rst) begin
            ones     <= '0;
            in_stuff <= 1'b0;
        end else if (emit) begin
            ones     <= emit_bit ? ones + 3'd1 : 3'd0;
            in_stuff <= do_stuff;
        end
    end
`else
    assign stuff_due = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        sr_n       = sr;
        nxt_n      = nxt;
        cur_last_n = cur_last;
        nxt_last_n = nxt_last;
        bit_cnt_n  = bit_cnt;
        dp_n       = d_plus;
        dm_n       = d_minus;
        emit       = 1'b0;
        emit_bit   = 1'b0;
        load_next  = 1'b0;
        ready_slot = 1'b0;

        case (state)
            ST_IDLE: begin
                dp_n = 1'b1;
                dm_n = 1'b0;
                if (tx_valid) begin
                    state_n    = ST_SYNC;
                    nxt_n      = tx_data;
                    nxt_last_n = tx_last;
                    bit_cnt_n  = '0;
                    emit       = 1'b1;
                    emit_bit   = SYNC_PATTERN[0];
                end
            end
            ST_SYNC: begin
                if (bit_end) begin
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        emit      = 1'b1;
                        emit_bit  = SYNC_PATTERN[bit_cnt_n];
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (stuff_due) begin
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                    end else if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        emit      = 1'b1;
                        emit_bit  = sr[0];
                        sr_n      = {1'b0, sr[7:1]};
                    end else if (cur_last) begin
                        state_n   = ST_EOP_SE0;
                        bit_cnt_n = '0;
                        dp_n      = 1'b0;
                        dm_n      = 1'b0;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    if (bit_cnt == 3'(EOP_SE0_BITS - 1)) begin
                        state_n = ST_EOP_J;
                        dp_n    = 1'b1;
                        dm_n    = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Start shifting the buffered byte; fetch its successor unless it is the last.
        if (load_next) begin
            ready_slot = !nxt_last;
            if (ready_slot && !tx_valid) begin
                state_n   = ST_EOP_SE0;
                bit_cnt_n = '0;
                dp_n      = 1'b0;
                dm_n      = 1'b0;
            end else begin
                state_n    = ST_DATA;
                emit       = 1'b1;
                emit_bit   = nxt[0];
                sr_n       = {1'b0, nxt[7:1]};
                cur_last_n = nxt_last;
                bit_cnt_n  = '0;
                if (ready_slot) begin
                    nxt_n      = tx_data;
                    nxt_last_n = tx_last;
                end
            end
        end

        if (emit && !emit_bit) begin
            dp_n = !dp_n;
            dm_n = !dm_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sr       <= '0;
            nxt      <= '0;
            cur_last <= 1'b0;
            nxt_last <= 1'b0;
            bit_cnt  <= '0;
            d_plus   <= 1'b1;
            d_minus  <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            nxt      <= nxt_n;
            cur_last <= cur_last_n;
            nxt_last <= nxt_last_n;
            bit_cnt  <= bit_cnt_n;
            d_plus   <= dp_n;
            d_minus  <= dm_n;
        end
    end

    assign tx_busy  = (state != ST_IDLE);
    assign tx_ready = ready_slot && !rst;
    assign tx_error = ready_slot && !tx_valid && !rst;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: a bit-level packet model predicts line symbols per bit period.
module tb_usb_tx_serializer;

    localparam int CPB = 8;
    localparam int BUDGET = 4000;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
`ifdef USB_TX_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_error;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pkt_q[$];
    logic [1:0] exp_q[$];
    logic [1:0] act_q[$];
    int exp_ready, exp_err, act_ready, act_err;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .d_plus  (d_plus),
        .d_minus (d_minus),
        .tx_busy (tx_busy),
        .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    // Reference: which bytes go out, raw bit stream, stuffing, NRZI, then EOP.
    task automatic build_model(input bit with_last);
        bit bits[$];
        bit stuffed[$];
        int run;
        int m;
        logic [1:0] line;
        m = pkt_q.size();
        exp_q.delete();
        exp_ready = 0;
        exp_err = 0;
        for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        for (int i = 0; i < m; i++) begin
            bit is_last;
            is_last = with_last && (i == m - 1);
            if (!is_last) begin
                exp_ready++;
                if (i + 1 >= m) begin
                    exp_err = 1;
                    break;
                end
            end
            for (int b = 0; b < 8; b++) bits.push_back(pkt_q[i][b]);
        end
        run = 0;
        foreach (bits[k]) begin
            stuffed.push_back(bits[k]);
            run = bits[k] ? run + 1 : 0;
            if (STUFF_ON && run == 6) begin
                stuffed.push_back(1'b0);
                run = 0;
            end
        end
        line = SYM_J;
        foreach (stuffed[k]) begin
            if (!stuffed[k]) line = (line == SYM_J) ? SYM_K : SYM_J;
            exp_q.push_back(line);
        end
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    // Drives pkt_q as an upstream source and records the line while tx_busy is high.
    task automatic run_packet(input string name, input bit with_last);
        int idx;
        int cycles;
        int m;
        int at;
        bit started;
        bit done;
        bit consume;
        bit bad;
        logic [1:0] got;
        m = pkt_q.size();
        idx = 0;
        cycles = 0;
        started = 0;
        done = 0;
        build_model(with_last);
        act_q.delete();
        act_ready = 0;
        act_err = 0;
        tx_valid = 1'b1;
        tx_data = pkt_q[0];
        tx_last = with_last && (m == 1);
        while (!done && cycles < BUDGET) begin
            @(negedge clk);
            if (tx_busy) begin
                started = 1;
                act_q.push_back({d_plus, d_minus});
            end else if (started) begin
                done = 1;
            end
            if (tx_ready) act_ready++;
            if (tx_error) act_err++;
            consume = tx_valid && (tx_ready || (!tx_busy && !started));
            @(posedge clk);
            #1;
            if (consume) begin
                idx++;
                if (idx < m) begin
                    tx_data = pkt_q[idx];
                    tx_last = with_last && (idx == m - 1);
                end else begin
                    tx_valid = 1'b0;
                end
            end
            cycles++;
        end
        tx_valid = 1'b0;

        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: busy still %b after %0d cycles, required idle", name, tx_busy, BUDGET);
        end
        vectors++;
        if (act_q.size() != exp_q.size() * CPB) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, act_q.size(), exp_q.size() * CPB);
        end
        foreach (exp_q[p]) begin
            vectors++;
            bad = 0;
            got = 2'bxx;
            for (int c = 0; c < CPB; c++) begin
                at = p * CPB + c;
                if (!bad && (at >= act_q.size() || act_q[at] !== exp_q[p])) begin
                    bad = 1;
                    if (at < act_q.size()) got = act_q[at];
                end
            end
            if (bad) begin
                miscompares++;
                $display("FAIL %s period %0d line {dp,dm}: got %b required %b", name, p, got, exp_q[p]);
            end
        end
        vectors++;
        if (act_ready != exp_ready) begin
            miscompares++;
            $display("FAIL %s tx_ready_pulses: got %0d required %0d", name, act_ready, exp_ready);
        end
        vectors++;
        if (act_err != exp_err) begin
            miscompares++;
            $display("FAIL %s tx_error_pulses: got %0d required %0d", name, act_err, exp_err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        tx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({d_plus, d_minus, tx_busy, tx_ready, tx_error} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_outputs {dp,dm,busy,ready,err}: got %b required 10000",
                     {d_plus, d_minus, tx_busy, tx_ready, tx_error});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({d_plus, d_minus, tx_busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_after_reset {dp,dm,busy}: got %b required 100", {d_plus, d_minus, tx_busy});
        end
    endtask

    task automatic test_single_a5;
        logic [1:0] tab[19];
        tab = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K,
                SYM_K, SYM_J, SYM_J, SYM_K, SYM_J, SYM_J, SYM_K, SYM_K,
                SYM_SE0, SYM_SE0, SYM_J};
        pkt_q = '{8'hA5};
        run_packet("single_a5", 1'b1);
        vectors++;
        if (act_q.size() != 152) begin
            miscompares++;
            $display("FAIL a5_busy_cycles: got %0d required 152", act_q.size());
        end
        for (int p = 0; p < 19; p++) begin
            vectors++;
            if (p * CPB + CPB / 2 >= act_q.size() || act_q[p * CPB + CPB / 2] !== tab[p]) begin
                miscompares++;
                $display("FAIL a5_table period %0d: got %b required %b", p,
                         (p * CPB + CPB / 2 < act_q.size()) ? act_q[p * CPB + CPB / 2] : 2'bxx, tab[p]);
            end
        end
    endtask

    task automatic test_stuffing;
        int req_periods;
        req_periods = STUFF_ON ? 28 : 27;
        pkt_q = '{8'hFF, 8'h00};
        run_packet("stuff_ff_00", 1'b1);
        vectors++;
        if (act_q.size() != req_periods * CPB) begin
            miscompares++;
            $display("FAIL stuff_total_cycles: got %0d required %0d", act_q.size(), req_periods * CPB);
        end
        vectors++;
        if (act_ready != 1) begin
            miscompares++;
            $display("FAIL stuff_ready_count: got %0d required 1", act_ready);
        end
    endtask

    task automatic test_underrun;
        pkt_q = '{8'h3C};
        run_packet("underrun_3c", 1'b0);
        vectors++;
        if (act_err != 1 || act_q.size() != 11 * CPB) begin
            miscompares++;
            $display("FAIL underrun_shape: got err=%0d cycles=%0d required err=1 cycles=%0d",
                     act_err, act_q.size(), 11 * CPB);
        end
    endtask

    task automatic test_back_to_back;
        pkt_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_packet("back_to_back", 1'b1);
        vectors++;
        if (act_ready != 2) begin
            miscompares++;
            $display("FAIL b2b_ready_count: got %0d required 2", act_ready);
        end
    endtask

    task automatic test_reset_mid_packet;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        tx_last = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (12 * CPB + 3) @(posedge clk);
        #1;
        vectors++;
        if (tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_packet_busy: got %b required 1", tx_busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({d_plus, d_minus, tx_busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_outputs {dp,dm,busy}: got %b required 100", {d_plus, d_minus, tx_busy});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        pkt_q = '{8'h81};
        run_packet("after_abort", 1'b1);
        vectors++;
        if (act_q.size() == 0 || act_q[0] !== SYM_K) begin
            miscompares++;
            $display("FAIL after_abort_first_symbol: got %b required %b",
                     (act_q.size() > 0) ? act_q[0] : 2'bxx, SYM_K);
        end
    endtask

    task automatic test_random;
        int m;
        bit with_last;
        for (int n = 0; n < 10; n++) begin
            m = $urandom_range(1, 4);
            with_last = ($urandom_range(0, 3) != 0);
            pkt_q.delete();
            for (int i = 0; i < m; i++) begin
                pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            run_packet($sformatf("random_%0d", n), with_last);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_stuffing();
        test_underrun();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
